// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 register file: clears x1..x31 after reset,
// then round-robin arbitrates valid/ready writeback requesters onto A3/WD3/WE3.
module regfile_wb_arbiter #(
  parameter  int NUM_REQ = 3,
  parameter  int ADDR_W  = 5,
  parameter  int DATA_W  = 32,
  localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ADDR_W-1:0]          A3,
  output logic [DATA_W-1:0]          WD3,
  output logic                       WE3,
  output logic                       init_done,
  output logic [GW-1:0]              last_grant
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CLR_LAST  = {ADDR_W{1'b1}};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   clr_idx_r;
  logic [GW-1:0]       rr_ptr_r;
  logic [GW-1:0]       grant_idx_s;
  logic                grant_hit_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic [ADDR_W-1:0]   addr_sel_s;
  logic [DATA_W-1:0]   data_sel_s;
  logic [GW-1:0]       rr_nxt_s;
  int unsigned         cand_s;

  // Round-robin search: walk downward so the candidate closest to rr_ptr wins last.
  always_comb begin
    grant_idx_s = '0;
    grant_hit_s = 1'b0;
    cand_s      = 32'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = int'(rr_ptr_r) + k;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      if (req_valid[GW'(cand_s)]) begin
        grant_hit_s = 1'b1;
        grant_idx_s = GW'(cand_s);
      end else begin
        grant_hit_s = grant_hit_s;
      end
    end
  end

  // One-hot ready, only while running and only toward a valid requester.
  always_comb begin
    ready_s = '0;
    if (state_r == ST_RUN && grant_hit_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign req_ready = ready_s;

  // Payload mux for the granted requester.
  always_comb begin
    addr_sel_s = '0;
    data_sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_idx_s) begin
        addr_sel_s = req_addr[i*ADDR_W +: ADDR_W];
        data_sel_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        addr_sel_s = addr_sel_s;
      end
    end
  end

  // Pointer moves just past the winner, wrapping at NUM_REQ-1.
  always_comb begin
    rr_nxt_s = '0;
    if (grant_idx_s == GW'(NUM_REQ - 1)) begin
      rr_nxt_s = '0;
    end else begin
      rr_nxt_s = grant_idx_s + GW'(1);
    end
  end

  // Next-state logic: INIT ends after the cycle that issues the last address.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (clr_idx_r == CLR_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write-port registers; init_done rises on the first RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx_r  <= CLR_FIRST;
      rr_ptr_r   <= '0;
      A3         <= '0;
      WD3        <= '0;
      WE3        <= 1'b0;
      init_done  <= 1'b0;
      last_grant <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          A3        <= clr_idx_r;
          WD3       <= '0;
          WE3       <= 1'b1;
          clr_idx_r <= clr_idx_r + ADDR_W'(1);
        end
        ST_RUN: begin
          init_done <= 1'b1;
          if (grant_hit_s) begin
            A3         <= addr_sel_s;
            WD3        <= data_sel_s;
            WE3        <= (addr_sel_s != '0);
            last_grant <= grant_idx_s;
            rr_ptr_r   <= rr_nxt_s;
          end else begin
            WE3 <= 1'b0;
          end
        end
        default: begin
          WE3 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32x32 register file. It shares the single write port (A3/WD3/WE3) between NUM_REQ writeback requesters using a valid/ready handshake and round-robin arbitration. After reset it runs a clear sequence that drives zero into x1..x31. Its registered outputs connect directly to the register file's A3, WD3 and WE3 inputs; the register file samples them on the falling edge.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8); index 0 = ALU, 1 = load, 2 = debug/trigger
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant, combinational from state and req_valid
- A3  output  ADDR_W  register-file write address (registered)
- WD3  output  DATA_W  register-file write data (registered)
- WE3  output  1  register-file write enable (registered)
- init_done  output  1  high once the clear sequence has completed
- last_grant  output  clog2(NUM_REQ)  index of the most recently accepted requester (registered)

## Operation
- The block has two states: INIT and RUN. Reset enters INIT.
- **INIT**
  - Counter clr_idx starts at 1.
  - Each cycle: A3<=clr_idx, WD3<=0, WE3<=1, clr_idx<=clr_idx+1.
  - req_ready is all zeros; req_valid is ignored.
  - After the cycle that issues A3=31: state<=RUN and init_done<=1.
  - x0 is never written.
- **RUN**
  - Round-robin pointer rr_ptr gives the highest-priority index.
  - The granted index is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At most one req_ready bit is high. The grant goes only to a valid requester. No valid requests means req_ready=0.
  - Transfer occurs when req_valid[i] & req_ready[i] at a rising edge. On transfer:
    - A3<=req_addr[i], WD3<=req_data[i]
    - WE3<=(req_addr[i]!=0)
    - last_grant<=i
    - rr_ptr<=(i+1) mod NUM_REQ
  - With no transfer: WE3<=0, and A3, WD3 and rr_ptr hold.
- **Requester rules**
  - A requester holds valid, addr and data stable until accepted.
  - A requester may not withdraw valid before acceptance.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- **Write to x0**: the request is accepted normally (ready asserted, pointer advances) but WE3 stays 0.
- **Same address from two requesters in one cycle**: no special handling. They are served in round-robin order on consecutive cycles, so the later grant's data ends up in the register.
- **Fairness**: a continuously valid requester is granted within NUM_REQ cycles.

## Timing
- **Reset values** (immediate on rst_n low, asynchronous):
  - state=INIT, clr_idx=1, rr_ptr=0
  - A3=0, WD3=0, WE3=0
  - init_done=0, last_grant=0
  - req_ready=0 (combinational consequence of state INIT)
- **Clear sequence**
  - First rising edge after rst_n deasserts: A3=1, WE3=1.
  - 31 consecutive write cycles, A3=1..31.
  - init_done=1 and WE3=0 from the 32nd edge onward (unless a request is accepted on that edge).
  - First req_ready can be high in the cycle after the 31st edge.
- **Write latency**
  - Accepting edge N drives A3/WD3/WE3 valid from edge N until edge N+1.
  - The register file commits on the falling edge between N and N+1.
  - A read of that register reflects the new value from that falling edge onward.
- **Throughput**: one write per cycle sustained, with back-to-back grants allowed.
- **Reset mid-operation**: any rst_n low, including mid-INIT, aborts in flight immediately. On release the full clear sequence restarts from x1. Pending requests are not accepted until init_done=1.

## Test plan
- **Reset/clear**: release rst_n, hold all req_valid=1.
  - Required: exactly 31 cycles with WE3=1, WD3=0, A3 stepping 1..31; req_ready=0 throughout; init_done rises after A3=31.
- **Single write**: after init, ALU (index 0) requests addr=5, data=0xDEADBEEF.
  - Required: req_ready=3'b001 that cycle; next cycle A3=5, WD3=0xDEADBEEF, WE3=1, last_grant=0; WE3=0 the following cycle.
- **Contention**: all three requesters continuously valid with addrs 1, 2, 3, rr_ptr=0.
  - Required: grants cycle in order 0, 1, 2, 0, ...; A3 sequence 1, 2, 3, 1 with WE3=1 every cycle.
- **x0 write**: load (index 1) requests addr=0, data=0x12345678.
  - Required: req_ready[1]=1, transfer accepted, last_grant=1, WE3=0, rr_ptr advances to 2.
- **Same-address race**: requesters 0 and 2 both write addr=10 with data 0xAAAA and 0xBBBB, rr_ptr=2.
  - Required: 0xBBBB written first, then 0xAAAA; a0 ends at 0xAAAA.
- **Reset mid-init**: assert rst_n low when A3=17.
  - Required: outputs go to reset values immediately; after release, clearing restarts at A3=1 and takes 31 further cycles.
